// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   state_t : controller states (IDLE, SHIFT, DONE)
//   OP_ADD / OP_SUB : encodings of the op input
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry/borrow D-flop.
// Ports:
//   clk, clear      : clock, asynchronous active-high reset
//   en              : advance the carry flop to cout_next (one bit time)
//   init, init_val  : load the carry flop with init_val (takes priority over en)
//   a, b            : operand bits for the current bit time
//   sum, cout_next  : combinational sum and carry-out of this bit time
//   carry_q         : carry held from the previous bit time
module serial_fa_cell (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic init,
    input  logic init_val,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout_next,
    output logic carry_q
);

    logic carry_d;

    always_comb begin
        sum       = a ^ b ^ carry_q;
        cout_next = (a & b) | (a & carry_q) | (b & carry_q);
        carry_d   = carry_q;
        if (init) begin
            carry_d = init_val;
        end else if (en) begin
            carry_d = cout_next;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Sequenced bit-serial add/subtract unit with start/done handshake.
// Operands are loaded on an accepted start, shifted LSB first through a single
// full-adder cell for WIDTH cycles, and the parallel result plus flags are
// latched on the last bit time.
// Ports:
//   clk, clear          : clock, asynchronous active-high reset
//   start, op           : request (sampled in IDLE only); 0 = A+B, 1 = A-B
//   a_in, b_in          : operands, sampled with an accepted start
//   busy, shift_control : high while shifting (identical signals)
//   done                : one-cycle completion pulse
//   result              : sum/difference, held until the next operation ends
//   carry_out           : final carry; for subtract 1 means no borrow
//   overflow            : signed overflow of the operation
module serial_addsub_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             shift_control,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
    logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic load;
    logic shift_en;
    logic fa_sum;
    logic fa_cout;
    logic fa_carry_q;

    serial_fa_cell u_fa (
        .clk       (clk),
        .clear     (clear),
        .en        (shift_en),
        .init      (load),
        .init_val  (op),
        .a         (sreg_a_q[0]),
        .b         (sreg_b_q[0]),
        .sum       (fa_sum),
        .cout_next (fa_cout),
        .carry_q   (fa_carry_q)
    );

    always_comb begin
        state_d     = state_q;
        sreg_a_d    = sreg_a_q;
        sreg_b_d    = sreg_b_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        load        = 1'b0;
        shift_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is A + ~B + 1: invert B here, carry flop gets op.
                    load     = 1'b1;
                    sreg_a_d = a_in;
                    sreg_b_d = (op == OP_SUB) ? ~b_in : b_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                sreg_a_d = sreg_a_q >> 1;
                sreg_b_d = sreg_b_q >> 1;
                // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
                res_sh_d = (res_sh_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Carry into the MSB is the held carry; out of it is fa_cout.
                    overflow_d  = fa_carry_q ^ fa_cout;
                    carry_out_d = fa_cout;
                    result_d    = res_sh_d;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            sreg_a_q    <= '0;
            sreg_b_q    <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_a_q    <= sreg_a_d;
            sreg_b_q    <= sreg_b_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy          = (state_q == SHIFT);
    assign shift_control = busy;
    assign done          = (state_q == DONE);
    assign result        = result_q;
    assign carry_out     = carry_out_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk;
    logic         clear;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         shift_control;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int   tests;
    int   fails;
    int   done_cnt;
    exp_t sbq[$];

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .clear         (clear),
        .start         (start),
        .op            (op),
        .a_in          (a_in),
        .b_in          (b_in),
        .busy          (busy),
        .done          (done),
        .shift_control (shift_control),
        .result        (result),
        .carry_out     (carry_out),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic: plain (WIDTH+1)-bit add of A and B / ~B + 1.
    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb   = o ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(o);
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: request is sampled on the next rising edge.
    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        sbq.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // k0 = cycle index (after the accepting edge) of the current falling edge.
    task automatic wait_done(input string tag, input int k0);
        int   k;
        int   nbusy;
        int   nsc;
        bit   seen;
        exp_t e;
        seen  = 1'b0;
        nbusy = 0;
        nsc   = 0;
        for (k = k0; k <= k0 + 20; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            if (shift_control === 1'b1) nsc++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(k), 32'(W + 1));
            chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W + 1 - k0));
            chk({tag, "_shift_ctl_cycles"}, 32'(nsc), 32'(W + 1 - k0));
            e = sbq.pop_front();
            chk({tag, "_result"}, 32'(result), 32'(e.r));
            chk({tag, "_carry_out"}, 32'(carry_out), 32'(e.c));
            chk({tag, "_overflow"}, 32'(overflow), 32'(e.v));
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            chk({tag, "_result_held"}, 32'(result), 32'(e.r));
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(o, a, b);
        wait_done(tag, 1);
    endtask

    initial begin
        int   d0;
        int   ndone;
        int   last;
        exp_t e;
        exp_t held;

        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        clear    = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        a_in     = '0;
        b_in     = '0;
        held     = '0;

        repeat (2) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_shift_ctl", 32'(shift_control), 32'd0);
        chk("rst_flags", 32'({carry_out, overflow}), 32'd0);
        clear = 1'b0;
        @(negedge clk);

        run_op("add_5_3", 1'b0, 4'd5, 4'd3);
        run_op("sub_7_2", 1'b1, 4'd7, 4'd2);
        run_op("sub_2_7", 1'b1, 4'd2, 4'd7);
        run_op("add_15_1", 1'b0, 4'd15, 4'd1);
        run_op("sub_8_1", 1'b1, 4'd8, 4'd1);

        // Second start during SHIFT must be ignored.
        d0 = done_cnt;
        issue(1'b0, 4'd3, 4'd1);
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_busy", 3);
        repeat (8) @(negedge clk);
        chk("start_busy_single_done", 32'(done_cnt - d0), 32'd1);

        // Asynchronous clear between edges in the middle of SHIFT.
        d0 = done_cnt;
        issue(1'b0, 4'd9, 4'd9);
        @(negedge clk);
        #2 clear = 1'b1;
        #1;
        chk("clr_result", 32'(result), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_shift_ctl", 32'(shift_control), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_flags", 32'({carry_out, overflow}), 32'd0);
        #1 clear = 1'b0;
        sbq.delete();
        repeat (8) @(negedge clk);
        chk("clr_no_done", 32'(done_cnt - d0), 32'd0);
        run_op("sub_6_6", 1'b1, 4'd6, 4'd6);

        // Start held high: completions every WIDTH+2 cycles.
        start = 1'b1;
        op    = 1'b0;
        a_in  = 4'd2;
        b_in  = 4'd3;
        sbq.push_back(model(1'b0, 4'd2, 4'd3));
        @(negedge clk);
        a_in = 4'd6;
        b_in = 4'd1;
        sbq.push_back(model(1'b0, 4'd6, 4'd1));
        sbq.push_back(model(1'b0, 4'd6, 4'd1));
        ndone = 0;
        last  = 0;
        for (int c = 1; c <= 40 && ndone < 3; c++) begin
            if (done === 1'b1) begin
                e = sbq.pop_front();
                chk("b2b_result", 32'(result), 32'(e.r));
                chk("b2b_carry_out", 32'(carry_out), 32'(e.c));
                chk("b2b_overflow", 32'(overflow), 32'(e.v));
                if (ndone == 0) chk("b2b_first_latency", 32'(c), 32'(W + 1));
                else            chk("b2b_period", 32'(c - last), 32'(W + 2));
                last = c;
                held = e;
                ndone++;
            end else if (ndone > 0) begin
                chk("b2b_result_stable", 32'(result), 32'(held.r));
            end
            if (ndone < 3) @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_completions", 32'(ndone), 32'd3);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
